// File: rtl/lsu_mem_master_if.sv
// Bundle of the pipeline request/response handshake and the data-memory bus
// seen by lsu_mem_master. The master modport is the LSU side; the slave
// modport is the environment (pipeline MEM stage plus data memory).
interface lsu_mem_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_fault;
    logic [63:0] mem_address;
    logic [63:0] mem_Data_write;
    logic        mem_MemWrite;
    logic        mem_MemRead;
    logic [63:0] mem_Data_read;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_Data_read,
        output req_ready, resp_valid, resp_rdata, resp_fault,
        output mem_address, mem_Data_write, mem_MemWrite, mem_MemRead
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_Data_read,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
        input  mem_address, mem_Data_write, mem_MemWrite, mem_MemRead
    );
endinterface

// File: rtl/lsu_mem_master.sv
// Load/store initiator between the MEM stage and a byte-addressed 64-bit
// data memory. One request at a time; sub-doubleword stores are done as
// read-modify-write because the memory always writes 8 bytes.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (fault on misaligned H/W/D).
module lsu_mem_master #(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic                  Clk,
    input  logic                  reset,
    lsu_mem_master_if.master      bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic        fault_q;
    logic [63:0] buf_q;

    logic [64:0] end_addr_s;
    logic        range_bad_s;
    logic        misalign_s;
    logic        req_fault_s;

    // Replace the low 2^size bytes of old_v with those of new_v.
    function automatic logic [63:0] merge_bytes(input logic [63:0] old_v,
                                                input logic [63:0] new_v,
                                                input logic [1:0]  size);
        logic [63:0] r;
        int          nbytes;
        nbytes = int'(4'd1 << size);
        for (int i = 0; i < 8; i++) begin
            if (i < nbytes) begin
                r[8*i +: 8] = new_v[8*i +: 8];
            end else begin
                r[8*i +: 8] = old_v[8*i +: 8];
            end
        end
        return r;
    endfunction

    // Size/sign extension of a loaded doubleword; funct3[2] selects zero-extend.
    function automatic logic [63:0] extend_load(input logic [63:0] b,
                                                input logic [2:0]  f3);
        logic [63:0] r;
        case (f3[1:0])
            2'b00:   r = f3[2] ? {56'd0, b[7:0]}  : {{56{b[7]}},  b[7:0]};
            2'b01:   r = f3[2] ? {48'd0, b[15:0]} : {{48{b[15]}}, b[15:0]};
            2'b10:   r = f3[2] ? {32'd0, b[31:0]} : {{32{b[31]}}, b[31:0]};
            2'b11:   r = b;
            default: r = b;
        endcase
        return r;
    endfunction

    // Request screening: reserved funct3, unsigned store, out-of-range window
    // (the 65-bit sum turns a wrap past 2^64 into an out-of-range value).
    always_comb begin
        end_addr_s  = {1'b0, bus.req_addr} + 65'd7;
        range_bad_s = (end_addr_s >= 65'(MEM_BYTES));
`ifdef LSU_MISALIGN_TRAP_EN
        case (bus.req_funct3[1:0])
            2'b01:   misalign_s = bus.req_addr[0];
            2'b10:   misalign_s = |bus.req_addr[1:0];
            2'b11:   misalign_s = |bus.req_addr[2:0];
            default: misalign_s = 1'b0;
        endcase
`else
        misalign_s = 1'b0;
`endif
        req_fault_s = (bus.req_funct3 == 3'b111) || (bus.req_we && bus.req_funct3[2])
                      || range_bad_s || misalign_s;
    end

    // State register, request latches and read buffer.
    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= 64'd0;
            wdata_q  <= 64'd0;
            fault_q  <= 1'b0;
            buf_q    <= 64'd0;
        end else begin
            state_q <= state_d;
            if ((state_q == S_IDLE) && bus.req_valid) begin
                we_q     <= bus.req_we;
                funct3_q <= bus.req_funct3;
                addr_q   <= bus.req_addr;
                wdata_q  <= bus.req_wdata;
                fault_q  <= req_fault_s;
            end
            if (state_q == S_RD) begin
                buf_q <= bus.mem_Data_read;
            end
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!bus.req_valid) begin
                    state_d = S_IDLE;
                end else if (req_fault_s) begin
                    state_d = S_RESP;
                end else if (bus.req_we && (bus.req_funct3 == 3'b011)) begin
                    state_d = S_WR;
                end else begin
                    state_d = S_RD;
                end
            end
            S_RD: begin
                if (we_q) begin
                    state_d = S_WR;
                end else begin
                    state_d = S_RESP;
                end
            end
            S_WR:    state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the current state; reset forces the memory
    // strobes and response low in the very cycle it is asserted.
    always_comb begin
        logic        rv_s, rf_s, mr_s, mw_s;
        logic [63:0] rd_s, ma_s, mdw_s;
        rv_s  = 1'b0;
        rf_s  = 1'b0;
        mr_s  = 1'b0;
        mw_s  = 1'b0;
        rd_s  = 64'd0;
        ma_s  = 64'd0;
        mdw_s = 64'd0;
        case (state_q)
            S_IDLE: begin
                rv_s = 1'b0;
            end
            S_RD: begin
                mr_s = 1'b1;
                ma_s = addr_q;
            end
            S_WR: begin
                mw_s  = 1'b1;
                ma_s  = addr_q;
                mdw_s = merge_bytes(buf_q, wdata_q, funct3_q[1:0]);
            end
            S_RESP: begin
                rv_s = 1'b1;
                rf_s = fault_q;
                if (!we_q && !fault_q) begin
                    rd_s = extend_load(buf_q, funct3_q);
                end else begin
                    rd_s = 64'd0;
                end
            end
            default: begin
                rv_s = 1'b0;
            end
        endcase

        bus.req_ready = (state_q == S_IDLE);
        if (reset) begin
            bus.resp_valid     = 1'b0;
            bus.resp_fault     = 1'b0;
            bus.resp_rdata     = 64'd0;
            bus.mem_MemRead    = 1'b0;
            bus.mem_MemWrite   = 1'b0;
            bus.mem_address    = 64'd0;
            bus.mem_Data_write = 64'd0;
        end else begin
            bus.resp_valid     = rv_s;
            bus.resp_fault     = rf_s;
            bus.resp_rdata     = rd_s;
            bus.mem_MemRead    = mr_s;
            bus.mem_MemWrite   = mw_s;
            bus.mem_address    = ma_s;
            bus.mem_Data_write = mdw_s;
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed self-checking bench for lsu_mem_master with a 1 KiB byte memory model.
module tb_lsu_mem_master;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_D  = 3'b011;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;
    localparam logic [2:0] F_WU = 3'b110;
    localparam logic [2:0] F_XX = 3'b111;

    logic Clk;
    logic reset;
    logic mem_init;
    logic [7:0]  mem_bytes [1024];
    logic [63:0] rd_word;
    int checks;
    int errors;
    int rd_cnt;
    int wr_cnt;
    int resp_cnt;
    int both_cnt;

    lsu_mem_master_if bus();

    lsu_mem_master #(.MEM_BYTES(1024)) dut (
        .Clk   (Clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Combinational memory read port.
    always_comb begin
        rd_word = 64'd0;
        if (bus.mem_address < 64'd1017) begin
            for (int i = 0; i < 8; i++) begin
                rd_word[8*i +: 8] = mem_bytes[int'(bus.mem_address[9:0]) + i];
            end
        end
    end
    assign bus.mem_Data_read = rd_word;

    // Memory write port: clear on init, 8-byte write on MemWrite.
    always @(posedge Clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) mem_bytes[i] <= 8'h00;
        end else if (bus.mem_MemWrite && (bus.mem_address < 64'd1017)) begin
            for (int i = 0; i < 8; i++) begin
                mem_bytes[int'(bus.mem_address[9:0]) + i] <= bus.mem_Data_write[8*i +: 8];
            end
        end
    end

    // Bus activity counters sampled mid-cycle.
    always @(negedge Clk) begin
        if (bus.mem_MemRead)  rd_cnt <= rd_cnt + 1;
        if (bus.mem_MemWrite) wr_cnt <= wr_cnt + 1;
        if (bus.resp_valid)   resp_cnt <= resp_cnt + 1;
        if (bus.mem_MemRead && bus.mem_MemWrite) both_cnt <= both_cnt + 1;
    end

    function automatic logic [63:0] mem_word(input int a);
        logic [63:0] w;
        for (int i = 0; i < 8; i++) w[8*i +: 8] = mem_bytes[a + i];
        return w;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one request (called #1 after a posedge with the DUT idle) and
    // wait for its response; returns data, fault and latency in cycles.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] wdata, output logic [63:0] rdata,
                          output logic fault, output int lat);
        bit got;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(posedge Clk);
        #1;
        bus.req_valid = 1'b0;
        lat = 1;
        got = 1'b0;
        rdata = 64'd0;
        fault = 1'b0;
        while (!got && (lat < 10)) begin
            @(negedge Clk);
            if (bus.resp_valid) begin
                got   = 1'b1;
                rdata = bus.resp_rdata;
                fault = bus.resp_fault;
            end else begin
                @(posedge Clk);
                lat++;
            end
        end
        if (!got) chk("resp_timeout", 64'd0, 64'd1);
        @(posedge Clk);
        #1;
    endtask

    task automatic run(input string tag, input logic we, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [63:0] exp_data, input logic exp_fault, input int exp_lat);
        logic [63:0] d;
        logic        f;
        int          l;
        do_req(we, f3, addr, wdata, d, f, l);
        chk({tag, "_data"},  d, exp_data);
        chk({tag, "_fault"}, {63'd0, f}, {63'd0, exp_fault});
        chk({tag, "_lat"},   64'(l), 64'(exp_lat));
    endtask

    initial begin
        int rd0, wr0, rs0;
        checks = 0; errors = 0;
        rd_cnt = 0; wr_cnt = 0; resp_cnt = 0; both_cnt = 0;
        reset = 1'b1; mem_init = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
        bus.req_addr = 64'd0; bus.req_wdata = 64'd0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("rst_ready",  {63'd0, bus.req_ready},    64'd1);
        chk("rst_rvalid", {63'd0, bus.resp_valid},   64'd0);
        chk("rst_rdata",  bus.resp_rdata,            64'd0);
        chk("rst_fault",  {63'd0, bus.resp_fault},   64'd0);
        chk("rst_mrd",    {63'd0, bus.mem_MemRead},  64'd0);
        chk("rst_mwr",    {63'd0, bus.mem_MemWrite}, 64'd0);
        chk("rst_addr",   bus.mem_address,           64'd0);
        chk("rst_wdata",  bus.mem_Data_write,        64'd0);
        @(posedge Clk); #1;
        reset = 1'b0; mem_init = 1'b0;

        // 1: doubleword store
        run("sd10", 1'b1, F_D, 64'h10, 64'h1122334455667788, 64'd0, 1'b0, 2);
        chk("sd10_mem", mem_word(16), 64'h1122334455667788);
        chk("sd10_b17", {56'd0, mem_bytes[23]}, 64'h11);

        // 2: loads of various sizes
        run("lb17", 1'b0, F_B, 64'h17, 64'd0, 64'h0000000000000011, 1'b0, 2);
        run("lw10", 1'b0, F_W, 64'h10, 64'd0, 64'h0000000055667788, 1'b0, 2);
        run("ld10", 1'b0, F_D, 64'h10, 64'd0, 64'h1122334455667788, 1'b0, 2);

        // 3: byte store via RMW, then signed/unsigned loads
        run("sb12", 1'b1, F_B, 64'h12, 64'h00000000000000FF, 64'd0, 1'b0, 3);
        run("ld10b", 1'b0, F_D, 64'h10, 64'd0, 64'h1122334455FF7788, 1'b0, 2);
        run("lb12",  1'b0, F_B, 64'h12, 64'd0, 64'hFFFFFFFFFFFFFFFF, 1'b0, 2);
        run("lbu12", 1'b0, F_BU, 64'h12, 64'd0, 64'h00000000000000FF, 1'b0, 2);
        run("lh11",  1'b0, F_H, 64'h11, 64'd0, 64'hFFFFFFFFFFFFFF77, 1'b0, 2);
        run("lhu11", 1'b0, F_HU, 64'h11, 64'd0, 64'h000000000000FF77, 1'b0, 2);
        run("sw30",  1'b1, F_W, 64'h30, 64'hDEAD_BEEF_8000_0001, 64'd0, 1'b0, 3);
        run("lw30",  1'b0, F_W, 64'h30, 64'd0, 64'hFFFFFFFF80000001, 1'b0, 2);
        run("lwu30", 1'b0, F_WU, 64'h30, 64'd0, 64'h0000000080000001, 1'b0, 2);
        chk("sw30_hi", mem_word(52), 64'd0);

        // 4: faults and range boundary
        rd0 = rd_cnt; wr0 = wr_cnt;
        run("ld1017", 1'b0, F_D, 64'd1017, 64'd0, 64'd0, 1'b1, 1);
        run("f3_111", 1'b0, F_XX, 64'h10, 64'd0, 64'd0, 1'b1, 1);
        run("sbu",    1'b1, F_BU, 64'h10, 64'hAB, 64'd0, 1'b1, 1);
        run("sb1017", 1'b1, F_B, 64'd1017, 64'hAB, 64'd0, 1'b1, 1);
        run("wrap",   1'b0, F_B, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 64'd0, 1'b1, 1);
        chk("flt_noread",  64'(rd_cnt - rd0), 64'd0);
        chk("flt_nowrite", 64'(wr_cnt - wr0), 64'd0);
        chk("ld10_intact", mem_word(16), 64'h1122334455FF7788);
        run("ld1016", 1'b0, F_D, 64'd1016, 64'd0, 64'd0, 1'b0, 2);

        // 5: misaligned halfword store
        run("sd28", 1'b1, F_D, 64'h28, 64'h00000000000000A9, 64'd0, 1'b0, 2);
        run("sd20", 1'b1, F_D, 64'h20, 64'h0807060504030201, 64'd0, 1'b0, 2);
`ifdef LSU_MISALIGN_TRAP_EN
        run("sh21", 1'b1, F_H, 64'h21, 64'h000000000000BEEF, 64'd0, 1'b1, 1);
        chk("sh21_mem", mem_word(32), 64'h0807060504030201);
`else
        run("sh21", 1'b1, F_H, 64'h21, 64'h000000000000BEEF, 64'd0, 1'b0, 3);
        chk("sh21_mem", mem_word(32), 64'h0807060504BEEF01);
`endif
        chk("sh21_b28", {56'd0, mem_bytes[40]}, 64'hA9);

        // 6: reset during RD of a word store
        rd0 = rd_cnt; wr0 = wr_cnt; rs0 = resp_cnt;
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = F_W;
        bus.req_addr = 64'h40; bus.req_wdata = 64'h00000000AABBCCDD;
        @(posedge Clk); #1;
        bus.req_valid = 1'b0;
        reset = 1'b1;
        @(posedge Clk); #1;
        reset = 1'b0;
        @(negedge Clk);
        chk("rst_rd_idle", {63'd0, bus.req_ready}, 64'd1);
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_rd_nowr",  64'(wr_cnt - wr0),   64'd0);
        chk("rst_rd_nore",  64'(resp_cnt - rs0), 64'd0);
        chk("rst_rd_mem",   mem_word(64), 64'd0);

        // 6b: req_valid held while busy yields one response
        rd0 = rd_cnt; rs0 = resp_cnt;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = F_D;
        bus.req_addr = 64'h10; bus.req_wdata = 64'd0;
        @(posedge Clk);
        @(negedge Clk);
        chk("busy_ready", {63'd0, bus.req_ready}, 64'd0);
        @(posedge Clk); #1;
        bus.req_valid = 1'b0;
        repeat (6) @(posedge Clk);
        #1;
        chk("busy_one_resp", 64'(resp_cnt - rs0), 64'd1);
        chk("busy_one_read", 64'(rd_cnt - rd0),   64'd1);
        chk("never_both",    64'(both_cnt),       64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
